// File: rtl/bus_arbiter.sv
// Bus control unit: shares the external bus between the prefetcher and the EU.
// Optional wait-state abort enabled by defining BUS_TIMEOUT_EN.
module bus_arbiter #(
  parameter logic [19:0] RESET_ADDR     = 20'hFFFFF,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        prefetch_req,
  input  logic [15:0] ps,
  input  logic [15:0] pfp,
  input  logic        queue_flush,
  output logic        queue_push,
  input  logic [1:0]  eu_bus_command,
  input  logic [19:0] eu_bus_address,
  input  logic [15:0] eu_write_data,
  output logic        eu_bus_done,
  input  logic        readyb,
  output logic [19:0] address_out,
  output logic [3:0]  bus_status,
  output logic [15:0] data_out,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EU_RD,
    EU_WR
  } state_t;

  localparam logic [3:0] ST_IDLE = 4'hF;
  localparam logic [3:0] ST_RD   = 4'b1001;
  localparam logic [3:0] ST_WR   = 4'b1010;

  state_t      state_q, state_d;
  logic [19:0] addr_q, addr_d;
  logic [3:0]  status_q, status_d;
  logic [15:0] data_q, data_d;
  logic        discard_q, discard_d;
  logic        discard_now;
  logic        expire;
  logic [19:0] fetch_addr;

  assign fetch_addr = {ps, 4'd0} + {4'd0, pfp};

`ifdef BUS_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 active;

  assign active = (state_q != IDLE);
  assign expire = active && readyb && (cnt_q == TMO_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!active)
      cnt_d = '0;
    else if (readyb && !expire)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  assign bus_timeout = expire;
  assign address_out = addr_q;
  assign bus_status  = status_q;
  assign data_out    = data_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    status_d    = status_q;
    data_d      = data_q;
    discard_d   = discard_q;
    discard_now = discard_q | queue_flush;
    queue_push  = 1'b0;
    eu_bus_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        status_d  = ST_IDLE;
        if (eu_bus_command == 2'b01) begin
          state_d  = EU_RD;
          addr_d   = eu_bus_address;
          status_d = ST_RD;
        end else if (eu_bus_command == 2'b10) begin
          state_d  = EU_WR;
          addr_d   = eu_bus_address;
          status_d = ST_WR;
          data_d   = eu_write_data;
        end else if (prefetch_req && !queue_flush) begin
          state_d  = FETCH;
          addr_d   = fetch_addr;
          status_d = ST_RD;
        end
      end
      FETCH: begin
        discard_d = discard_now;
        if (!readyb || expire) begin
          // a timed-out fetch never reaches the queue
          queue_push = !readyb && !discard_now;
          state_d    = IDLE;
          status_d   = ST_IDLE;
          discard_d  = 1'b0;
        end
      end
      EU_RD, EU_WR: begin
        if (!readyb || expire) begin
          eu_bus_done = 1'b1;
          state_d     = IDLE;
          status_d    = ST_IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        status_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= RESET_ADDR;
      status_q  <= ST_IDLE;
      data_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      status_q  <= status_d;
      data_q    <= data_d;
      discard_q <= discard_d;
    end
  end

endmodule
